// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/shared-memory bundle for the multi-cycle RV32 sequencer.
// master = controller side, slave = datapath + memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic             alusrc;
  logic [1:0]       aluop;
  logic             memreg;
  logic             regwrite;
  logic             jump;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output mem_req, iord, memread, memwrite, ir_write, pc_write, branch,
           alusrc, aluop, memreg, regwrite, jump, trap, trap_cause, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, iord, memread, memwrite, ir_write, pc_write, branch,
           alusrc, aluop, memreg, regwrite, jump, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, with illegal-opcode / memory-timeout trap and retire counter.
module multicycle_control #(
  parameter int ENABLE_JAL  = 1,
  parameter int ENABLE_LUI  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam int              WC_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LIM = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state;
  logic [6:0]       opcode_q;
  logic [WC_W-1:0]  wait_cnt;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] retired_q;

  logic req_st, stall, expire, legal;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_I, OP_BEQ: is_legal = 1'b1;
      OP_JAL:                           is_legal = (ENABLE_JAL != 0);
      OP_LUI:                           is_legal = (ENABLE_LUI != 0);
      default:                          is_legal = 1'b0;
    endcase
  endfunction

  // Only FETCH and MEM own the memory port, so only they can stall or time out.
  always_comb begin
    req_st = (state == S_FETCH) || (state == S_MEM);
    stall  = req_st && !bus.mem_ready;
    expire = (MEM_TIMEOUT != 0) && stall && (wait_cnt == WC_LIM);
    legal  = is_legal(bus.opcode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      opcode_q  <= '0;
      wait_cnt  <= '0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      wait_cnt <= (stall && !expire) ? wait_cnt + 1'b1 : '0;
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) state <= S_DECODE;
          else if (expire) begin
            state   <= S_TRAP;
            cause_q <= 2'b10;
          end
        end
        S_DECODE: begin
          opcode_q <= bus.opcode;
          if (legal) state <= S_EXEC;
          else begin
            state   <= S_TRAP;
            cause_q <= 2'b01;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_R, OP_I, OP_JAL, OP_LUI: state <= S_WB;
            OP_LW, OP_SW:               state <= S_MEM;
            OP_BEQ: begin
              state     <= S_FETCH;
              retired_q <= retired_q + 1'b1;
            end
            default: begin
              state   <= S_TRAP;
              cause_q <= 2'b01;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (opcode_q == OP_LW) state <= S_WB;
            else begin
              state     <= S_FETCH;
              retired_q <= retired_q + 1'b1;
            end
          end else if (expire) begin
            state   <= S_TRAP;
            cause_q <= 2'b10;
          end
        end
        S_WB: begin
          state     <= S_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        S_TRAP: state <= S_TRAP;
        default: begin
          state   <= S_TRAP;
          cause_q <= 2'b01;
        end
      endcase
    end
  end

  // Controls decode from state/opcode_q; gating with rst_n drops the request
  // the moment reset asserts rather than at the next edge.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.iord     = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.branch   = 1'b0;
    bus.alusrc   = 1'b0;
    bus.aluop    = 2'b00;
    bus.memreg   = 1'b0;
    bus.regwrite = 1'b0;
    bus.jump     = 1'b0;
    bus.trap     = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.memread  = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_EXEC: begin
          case (opcode_q)
            OP_R: bus.aluop = 2'b10;
            OP_I: begin
              bus.aluop  = 2'b10;
              bus.alusrc = 1'b1;
            end
            OP_LW, OP_SW: bus.alusrc = 1'b1;
            OP_BEQ: begin
              bus.aluop  = 2'b01;
              bus.branch = 1'b1;
            end
            OP_JAL: begin
              bus.pc_write = 1'b1;
              bus.jump     = 1'b1;
            end
            OP_LUI: begin
              bus.aluop  = 2'b11;
              bus.alusrc = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.alusrc   = 1'b1;
          bus.memread  = (opcode_q == OP_LW);
          bus.memwrite = (opcode_q == OP_SW);
        end
        S_WB: begin
          bus.regwrite = 1'b1;
          bus.memreg   = (opcode_q == OP_LW);
          bus.jump     = (opcode_q == OP_JAL);
        end
        S_TRAP: bus.trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: dut0 has JAL on, 4-cycle timeout and a
// 2-bit retire counter; dut1 has JAL disabled for the illegal-JAL case.
module tb_multicycle_control;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req,iord,memread,memwrite,ir_write,pc_write,branch}_alusrc_aluop_{memreg,regwrite,jump,trap}
  localparam logic [13:0] C_DEC    = 14'b0000000_0_00_0000;
  localparam logic [13:0] C_FW     = 14'b1010000_0_00_0000;
  localparam logic [13:0] C_FR     = 14'b1010110_0_00_0000;
  localparam logic [13:0] C_EX_R   = 14'b0000000_0_10_0000;
  localparam logic [13:0] C_EX_I   = 14'b0000000_1_10_0000;
  localparam logic [13:0] C_EX_M   = 14'b0000000_1_00_0000;
  localparam logic [13:0] C_EX_B   = 14'b0000001_0_01_0000;
  localparam logic [13:0] C_EX_J   = 14'b0000010_0_00_0010;
  localparam logic [13:0] C_EX_U   = 14'b0000000_1_11_0000;
  localparam logic [13:0] C_MEM_LW = 14'b1110000_1_00_0000;
  localparam logic [13:0] C_MEM_SW = 14'b1101000_1_00_0000;
  localparam logic [13:0] C_WB     = 14'b0000000_0_00_0100;
  localparam logic [13:0] C_WB_LW  = 14'b0000000_0_00_1100;
  localparam logic [13:0] C_WB_J   = 14'b0000000_0_00_0110;
  localparam logic [13:0] C_TRAP   = 14'b0000000_0_00_0001;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(2))  b0 ();
  multicycle_control_if #(.CNT_W(32)) b1 ();

  multicycle_control #(.ENABLE_JAL(1), .ENABLE_LUI(1), .MEM_TIMEOUT(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master)
  );
  multicycle_control #(.ENABLE_JAL(0), .ENABLE_LUI(1), .MEM_TIMEOUT(16), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1.master)
  );

  logic [13:0] ctl0, ctl1;
  assign ctl0 = {b0.mem_req, b0.iord, b0.memread, b0.memwrite, b0.ir_write, b0.pc_write,
                 b0.branch, b0.alusrc, b0.aluop, b0.memreg, b0.regwrite, b0.jump, b0.trap};
  assign ctl1 = {b1.mem_req, b1.iord, b1.memread, b1.memwrite, b1.ir_write, b1.pc_write,
                 b1.branch, b1.alusrc, b1.aluop, b1.memreg, b1.regwrite, b1.jump, b1.trap};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst1_n = 1'b0;
    b0.opcode = '0; b0.mem_ready = 1'b0;
    b1.opcode = '0; b1.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_DEC) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl0, C_DEC); end
    n_chk++; if (b0.retired !== 2'd0) begin n_fail++; $display("FAIL rst_retired: got %0d want 0", b0.retired); end
    n_chk++; if (b0.trap_cause !== 2'b00) begin n_fail++; $display("FAIL rst_cause: got %b want 00", b0.trap_cause); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FW) begin n_fail++; $display("FAIL rst_release: got %b want %b", ctl0, C_FW); end
    tick();
  endtask

  task automatic test_r_type();
    b0.opcode = OP_R; b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL r_fetch: got %b want %b", ctl0, C_FR); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_DEC) begin n_fail++; $display("FAIL r_decode: got %b want %b", ctl0, C_DEC); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_EX_R) begin n_fail++; $display("FAIL r_exec: got %b want %b", ctl0, C_EX_R); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_WB) begin n_fail++; $display("FAIL r_wb: got %b want %b", ctl0, C_WB); end
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL r_ret_before: got %0d want %0d", b0.retired, 2'(exp_ret)); end
    tick(); exp_ret++;
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL r_retired: got %0d want %0d", b0.retired, 2'(exp_ret)); end
  endtask

  task automatic test_lw();
    b0.opcode = OP_LW; b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL lw_fetch: got %b want %b", ctl0, C_FR); end
    tick(); tick();
    b0.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_EX_M) begin n_fail++; $display("FAIL lw_exec: got %b want %b", ctl0, C_EX_M); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (ctl0 !== C_MEM_LW) begin n_fail++; $display("FAIL lw_mem_wait%0d: got %b want %b", i, ctl0, C_MEM_LW); end
      tick();
    end
    b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_MEM_LW) begin n_fail++; $display("FAIL lw_mem_done: got %b want %b", ctl0, C_MEM_LW); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_WB_LW) begin n_fail++; $display("FAIL lw_wb: got %b want %b", ctl0, C_WB_LW); end
    tick(); exp_ret++;
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL lw_retired: got %0d want %0d", b0.retired, 2'(exp_ret)); end
  endtask

  task automatic test_sw_beq();
    b0.opcode = OP_SW; b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL sw_fetch: got %b want %b", ctl0, C_FR); end
    tick(); tick();
    b0.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_EX_M) begin n_fail++; $display("FAIL sw_exec: got %b want %b", ctl0, C_EX_M); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_MEM_SW) begin n_fail++; $display("FAIL sw_mem_wait: got %b want %b", ctl0, C_MEM_SW); end
    tick();
    b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_MEM_SW) begin n_fail++; $display("FAIL sw_mem_done: got %b want %b", ctl0, C_MEM_SW); end
    tick(); exp_ret++;
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL sw_retired: got %0d want %0d", b0.retired, 2'(exp_ret)); end
    b0.opcode = OP_BEQ;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL beq_fetch: got %b want %b", ctl0, C_FR); end
    tick(); tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_EX_B) begin n_fail++; $display("FAIL beq_exec: got %b want %b", ctl0, C_EX_B); end
    tick(); exp_ret++;
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL beq_retired: got %0d want %0d", b0.retired, 2'(exp_ret)); end
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL beq_branch_once: got %b want %b", ctl0, C_FR); end
  endtask

  task automatic test_jal_lui_i();
    logic [6:0]  ops [3];
    logic [13:0] ex  [3];
    logic [13:0] wb  [3];
    ops[0] = OP_JAL; ex[0] = C_EX_J; wb[0] = C_WB_J;
    ops[1] = OP_LUI; ex[1] = C_EX_U; wb[1] = C_WB;
    ops[2] = OP_I;   ex[2] = C_EX_I; wb[2] = C_WB;
    b0.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b0.opcode = ops[k];
      tick(); tick(); @(negedge clk);
      n_chk++; if (ctl0 !== ex[k]) begin n_fail++; $display("FAIL op%0d_exec: got %b want %b", k, ctl0, ex[k]); end
      tick(); @(negedge clk);
      n_chk++; if (ctl0 !== wb[k]) begin n_fail++; $display("FAIL op%0d_wb: got %b want %b", k, ctl0, wb[k]); end
      tick(); exp_ret++;
      n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL op%0d_retired: got %0d want %0d", k, b0.retired, 2'(exp_ret)); end
    end
  endtask

  task automatic test_reset_mid_mem();
    b0.opcode = OP_LW; b0.mem_ready = 1'b1;
    tick(); tick();
    b0.mem_ready = 1'b0;
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_MEM_LW) begin n_fail++; $display("FAIL mid_mem_req: got %b want %b", ctl0, C_MEM_LW); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ctl0 !== C_DEC) begin n_fail++; $display("FAIL mid_rst_ctl: got %b want %b", ctl0, C_DEC); end
    n_chk++; if (b0.retired !== 2'd0) begin n_fail++; $display("FAIL mid_rst_retired: got %0d want 0", b0.retired); end
    tick();
    rst_n = 1'b1; exp_ret = 0;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FW) begin n_fail++; $display("FAIL mid_rst_release: got %b want %b", ctl0, C_FW); end
    tick();
  endtask

  task automatic test_wrap();
    b0.opcode = OP_R; b0.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); tick(); tick(); tick();
      n_chk++; if (b0.retired !== 2'(i + 1)) begin n_fail++; $display("FAIL wrap_step%0d: got %0d want %0d", i, b0.retired, 2'(i + 1)); end
    end
    exp_ret = 5;
    n_chk++; if (b0.retired !== 2'd1) begin n_fail++; $display("FAIL wrap_retired: got %0d want 1", b0.retired); end
  endtask

  task automatic test_timeout();
    b0.opcode = OP_R; b0.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (ctl0 !== C_FW) begin n_fail++; $display("FAIL to_wait%0d: got %b want %b", i, ctl0, C_FW); end
      tick();
    end
    b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL to_limit_ready: got %b want %b", ctl0, C_FR); end
    tick();
    n_chk++; if (ctl0 !== C_DEC) begin n_fail++; $display("FAIL to_no_trap: got %b want %b", ctl0, C_DEC); end
    tick(); tick(); tick(); exp_ret++;
    b0.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (ctl0 !== C_FW) begin n_fail++; $display("FAIL to_stall%0d: got %b want %b", i, ctl0, C_FW); end
      tick();
    end
    n_chk++; if (ctl0 !== C_TRAP) begin n_fail++; $display("FAIL to_trap: got %b want %b", ctl0, C_TRAP); end
    n_chk++; if (b0.trap_cause !== 2'b10) begin n_fail++; $display("FAIL to_cause: got %b want 10", b0.trap_cause); end
    b0.mem_ready = 1'b1;
    tick(); tick(); tick();
    n_chk++; if (ctl0 !== C_TRAP) begin n_fail++; $display("FAIL to_sticky: got %b want %b", ctl0, C_TRAP); end
    n_chk++; if (b0.retired !== 2'(exp_ret)) begin n_fail++; $display("FAIL to_frozen: got %0d want %0d", b0.retired, 2'(exp_ret)); end
  endtask

  task automatic test_illegal();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; exp_ret = 0;
    b0.opcode = OP_BAD; b0.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl0 !== C_FR) begin n_fail++; $display("FAIL ill_fetch: got %b want %b", ctl0, C_FR); end
    tick(); @(negedge clk);
    n_chk++; if (ctl0 !== C_DEC) begin n_fail++; $display("FAIL ill_decode: got %b want %b", ctl0, C_DEC); end
    tick();
    n_chk++; if (ctl0 !== C_TRAP) begin n_fail++; $display("FAIL ill_trap: got %b want %b", ctl0, C_TRAP); end
    n_chk++; if (b0.trap_cause !== 2'b01) begin n_fail++; $display("FAIL ill_cause: got %b want 01", b0.trap_cause); end
    tick(); tick(); tick();
    n_chk++; if (ctl0 !== C_TRAP) begin n_fail++; $display("FAIL ill_sticky: got %b want %b", ctl0, C_TRAP); end
    n_chk++; if (b0.retired !== 2'd0) begin n_fail++; $display("FAIL ill_retired: got %0d want 0", b0.retired); end
  endtask

  task automatic test_jal_disabled();
    b1.opcode = OP_JAL; b1.mem_ready = 1'b1;
    rst1_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl1 !== C_FR) begin n_fail++; $display("FAIL njal_fetch: got %b want %b", ctl1, C_FR); end
    tick(); @(negedge clk);
    n_chk++; if (ctl1 !== C_DEC) begin n_fail++; $display("FAIL njal_decode: got %b want %b", ctl1, C_DEC); end
    tick();
    n_chk++; if (ctl1 !== C_TRAP) begin n_fail++; $display("FAIL njal_trap: got %b want %b", ctl1, C_TRAP); end
    n_chk++; if (b1.trap_cause !== 2'b01) begin n_fail++; $display("FAIL njal_cause: got %b want 01", b1.trap_cause); end
    n_chk++; if (b1.retired !== 32'd0) begin n_fail++; $display("FAIL njal_retired: got %0d want 0", b1.retired); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw_beq();
    test_jal_lui_i();
    test_reset_mid_mem();
    test_wrap();
    test_timeout();
    test_illegal();
    test_jal_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
